// File: rtl/di_arbiter.sv
// -----------------------------------------------------------------------------
// di_arbiter
//
// Shares one device-interface register bus between NUM_REQ masters. Requests
// are serialised with round-robin fairness: each transaction is latched onto
// the di_* bus, a one-cycle read/write strobe is issued, and the arbiter waits
// for di_rdwr_ready or a watchdog expiry before acking the granted master.
//
// Ports
//   if_clock         sole clock, rising edge
//   reset            asynchronous, active-high reset
//   req_valid        per-master request level, sampled only when idle
//   req_write        per-master direction (1 = write, 0 = read)
//   req_ep           per-master endpoint address, 16 bits per master
//   req_addr         per-master register address, 16 bits per master
//   req_wdata        per-master write data, 16 bits per master
//   req_ack          one-cycle completion pulse to the granted master
//   req_timeout      qualifies req_ack: the transaction was abandoned
//   req_rdata        read data, valid with req_ack and held until the next ack
//   grant            one-hot bus owner, zero when idle
//   busy             high whenever a transaction is in flight
//   di_ep_addr       downstream endpoint address
//   di_reg_addr      downstream register address
//   di_reg_data_in   downstream write data
//   di_write         one-cycle write strobe
//   di_read          one-cycle read strobe
//   di_reg_data_out  downstream read data
//   di_rdwr_ready    downstream completion strobe
// -----------------------------------------------------------------------------
module di_arbiter #(
    parameter int          NUM_REQ = 2,
    parameter int          TIMEOUT = 255,
    parameter int          CNT_W   = 8,
    parameter logic [15:0] TO_DATA = 16'hFFFF
) (
    input  logic                   if_clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [16*NUM_REQ-1:0]  req_ep,
    input  logic [16*NUM_REQ-1:0]  req_addr,
    input  logic [16*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   req_timeout,
    output logic [15:0]            req_rdata,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [15:0]            di_ep_addr,
    output logic [15:0]            di_reg_addr,
    output logic [15:0]            di_reg_data_in,
    output logic                   di_write,
    output logic                   di_read,
    input  logic [15:0]            di_reg_data_out,
    input  logic                   di_rdwr_ready
);

    localparam int                IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0]    NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 wr_q, wr_d;
    logic [15:0]          ep_q, ep_d;
    logic [15:0]          addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;
    logic                 di_write_q, di_write_d;
    logic                 di_read_q, di_read_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 timeout_q, timeout_d;
    logic [15:0]          rdata_q, rdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Round-robin pick: first requester at or after rr_q, wrapping.
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W:0]       cand;

    always_comb begin
        found   = 1'b0;
        win_idx = rr_q;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!found && req_valid[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    // NOTE: every next-state signal gets its hold/idle value first, so no
    // branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        idx_d      = idx_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        wr_d       = wr_q;
        ep_d       = ep_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        di_write_d = 1'b0;
        di_read_d  = 1'b0;
        ack_d      = '0;
        timeout_d  = 1'b0;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    idx_d      = win_idx;
                    grant_d    = NUM_REQ'(1) << win_idx;
                    busy_d     = 1'b1;
                    wr_d       = req_write[win_idx];
                    ep_d       = req_ep[{win_idx, 4'b0000} +: 16];
                    addr_d     = req_addr[{win_idx, 4'b0000} +: 16];
                    wdata_d    = req_wdata[{win_idx, 4'b0000} +: 16];
                    // Strobe is registered here so it is high during ISSUE.
                    di_write_d = req_write[win_idx];
                    di_read_d  = !req_write[win_idx];
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Any ready seen while the strobe is still out is stale.
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Ready takes priority over a simultaneous watchdog expiry.
                if (di_rdwr_ready) begin
                    ack_d   = grant_q;
                    if (!wr_q) begin
                        rdata_d = di_reg_data_out;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    ack_d     = grant_q;
                    timeout_d = 1'b1;
                    if (!wr_q) begin
                        rdata_d = TO_DATA;
                    end
                    state_d   = S_DONE;
                end
            end

            S_DONE: begin
                rr_d    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge if_clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            idx_q      <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            wr_q       <= 1'b0;
            ep_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            di_write_q <= 1'b0;
            di_read_q  <= 1'b0;
            ack_q      <= '0;
            timeout_q  <= 1'b0;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            wr_q       <= wr_d;
            ep_q       <= ep_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            di_write_q <= di_write_d;
            di_read_q  <= di_read_d;
            ack_q      <= ack_d;
            timeout_q  <= timeout_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_ack        = ack_q;
    assign req_timeout    = timeout_q;
    assign req_rdata      = rdata_q;
    assign grant          = grant_q;
    assign busy           = busy_q;
    assign di_ep_addr     = ep_q;
    assign di_reg_addr    = addr_q;
    assign di_reg_data_in = wdata_q;
    assign di_write       = di_write_q;
    assign di_read        = di_read_q;

endmodule

// File: tb/tb_di_arbiter.sv
// -----------------------------------------------------------------------------
// tb_di_arbiter
//
// Drives transactions into di_arbiter and compares every observable output
// with a transaction-level reference: round-robin winner picked by scanning
// from the fairness pointer, ack cycle computed from the ready delay and the
// watchdog limit, read data tracked as "last completed read".
// -----------------------------------------------------------------------------
module tb_di_arbiter;

    localparam int N = 3;
    localparam int T = 12;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [16*N-1:0]   req_ep;
    logic [16*N-1:0]   req_addr;
    logic [16*N-1:0]   req_wdata;
    logic [N-1:0]      req_ack;
    logic              req_timeout;
    logic [15:0]       req_rdata;
    logic [N-1:0]      grant;
    logic              busy;
    logic [15:0]       di_ep_addr;
    logic [15:0]       di_reg_addr;
    logic [15:0]       di_reg_data_in;
    logic              di_write;
    logic              di_read;
    logic [15:0]       di_reg_data_out;
    logic              di_rdwr_ready;

    logic [15:0]       ep_a    [N];
    logic [15:0]       addr_a  [N];
    logic [15:0]       wdata_a [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_ep[16*g +: 16]    = ep_a[g];
        assign req_addr[16*g +: 16]  = addr_a[g];
        assign req_wdata[16*g +: 16] = wdata_a[g];
    end

    di_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (T),
        .CNT_W   (8),
        .TO_DATA (16'hFFFF)
    ) dut (
        .if_clock        (clk),
        .reset           (rst),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_ep          (req_ep),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ack         (req_ack),
        .req_timeout     (req_timeout),
        .req_rdata       (req_rdata),
        .grant           (grant),
        .busy            (busy),
        .di_ep_addr      (di_ep_addr),
        .di_reg_addr     (di_reg_addr),
        .di_reg_data_in  (di_reg_data_in),
        .di_write        (di_write),
        .di_read         (di_read),
        .di_reg_data_out (di_reg_data_out),
        .di_rdwr_ready   (di_rdwr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state.
    int          rr_m    = 0;
    logic [15:0] rdata_m = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] mask, input int rr);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (rr + i) % N;
            if (((mask >> j) & N'(1)) != '0) return j;
        end
        return -1;
    endfunction

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            ep_a[i]    = 16'($urandom);
            addr_a[i]  = 16'($urandom);
            wdata_a[i] = 16'($urandom);
        end
    endtask

    // Runs one transaction starting at a negedge in an idle cycle and ends at
    // the negedge of the following idle cycle.
    //   d     : ready driven d cycles after the strobe cycle (1..T); T+1 = never
    //   stale : also pulse ready in the strobe cycle
    //   late  : also pulse ready in the turnaround cycle after the ack
    //   hold  : winner keeps requesting after its ack
    //   scram : rewrite every request input while the transaction is in flight
    task automatic run_txn(input logic [N-1:0] mask, input logic [N-1:0] wmask,
                           input int d, input logic [15:0] rd_val,
                           input bit stale, input bit late, input bit hold,
                           input bit scram);
        int          w;
        int          exp_k;
        int          early;
        int          strobes;
        bit          timed;
        bit          e_wr;
        logic [N-1:0] e_g;
        logic [15:0] e_ep;
        logic [15:0] e_addr;
        logic [15:0] e_wd;

        req_valid = mask;
        req_write = wmask;
        w      = pick(mask, rr_m);
        e_g    = N'(1) << w;
        e_wr   = ((wmask >> w) & N'(1)) != '0;
        e_ep   = ep_a[w];
        e_addr = addr_a[w];
        e_wd   = wdata_a[w];
        timed  = !(d >= 1 && d <= T);
        exp_k  = timed ? T + 2 : d + 2;
        early  = 0;
        strobes = 0;

        // Strobe cycle.
        @(negedge clk);
        check("issue_grant", 64'(grant), 64'(e_g));
        check("issue_busy", 64'(busy), 64'(1));
        check("issue_rd", 64'(di_read), 64'(!e_wr));
        check("issue_wr", 64'(di_write), 64'(e_wr));
        check("issue_bus", {16'h0, di_ep_addr, di_reg_addr, di_reg_data_in},
              {16'h0, e_ep, e_addr, e_wd});
        if (di_read || di_write) strobes++;
        if (req_ack != '0) early++;
        di_rdwr_ready   = stale;
        di_reg_data_out = 16'($urandom);

        for (int k = 2; k < exp_k; k++) begin
            @(negedge clk);
            if (req_ack != '0) early++;
            if (di_read || di_write) strobes++;
            if (k == 2 && scram) begin
                randomize_fields();
                req_valid = N'($urandom);
                req_write = N'($urandom);
            end
            di_rdwr_ready   = (k == 1 + d);
            di_reg_data_out = (k == 1 + d) ? rd_val : 16'($urandom);
        end

        // Ack cycle.
        @(negedge clk);
        if (di_read || di_write) strobes++;
        if (!e_wr) rdata_m = timed ? 16'hFFFF : rd_val;
        check("no_early_ack", 64'(early), 64'(0));
        check("strobe_count", 64'(strobes), 64'(1));
        check("ack", 64'(req_ack), 64'(e_g));
        check("ack_timeout", 64'(req_timeout), 64'(timed));
        check("ack_rdata", 64'(req_rdata), 64'(rdata_m));
        check("ack_grant", 64'(grant), 64'(e_g));
        di_rdwr_ready   = late;
        di_reg_data_out = 16'($urandom);
        req_valid       = hold ? mask : (mask & ~e_g);

        // Back to idle.
        @(negedge clk);
        di_rdwr_ready = 1'b0;
        check("idle_grant", 64'(grant), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_ack", 64'({req_ack, req_timeout}), 64'(0));
        check("idle_rdata", 64'(req_rdata), 64'(rdata_m));
        check("idle_bus", {16'h0, di_ep_addr, di_reg_addr, di_reg_data_in},
              {16'h0, e_ep, e_addr, e_wd});
        rr_m = (w + 1) % N;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus"}, {di_ep_addr, di_reg_addr, di_reg_data_in, req_rdata}, 64'(0));
        check({tag, "_ctl"}, 64'({req_ack, req_timeout, grant, busy, di_write, di_read}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst             = 1'b1;
        req_valid       = '0;
        req_write       = '0;
        di_rdwr_ready   = 1'b0;
        di_reg_data_out = '0;
        for (int i = 0; i < N; i++) begin
            ep_a[i]    = '0;
            addr_a[i]  = '0;
            wdata_a[i] = '0;
        end

        // Reset state.
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b0;

        // Round robin: masters 0 and 1 request continuously, ready at once.
        randomize_fields();
        for (int i = 0; i < 4; i++) begin
            run_txn(3'b011, 3'b000, 1, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Single read from master 0.
        ep_a[0] = 16'h0003; addr_a[0] = 16'h0010;
        run_txn(3'b001, 3'b000, 3, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single write from master 1; read data must stay 0xBEEF.
        ep_a[1] = 16'h0001; addr_a[1] = 16'h0002; wdata_a[1] = 16'h1234;
        run_txn(3'b010, 3'b010, 2, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout read, then a normal read.
        run_txn(3'b100, 3'b000, T + 1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(3'b100, 3'b000, 1, 16'h0A0A, 1'b0, 1'b0, 1'b0, 1'b0);

        // Boundaries: stale ready, ready on expiry, late ready.
        run_txn(3'b001, 3'b000, 3, 16'h1357, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(3'b010, 3'b000, T, 16'h2468, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(3'b100, 3'b000, 2, 16'h3579, 1'b0, 1'b1, 1'b0, 1'b0);
        run_txn(3'b111, 3'b000, 1, 16'h4680, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a wait; leave the pointer non-zero first.
        run_txn(3'b001, 3'b000, 1, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0);
        req_valid = 3'b100;
        req_write = 3'b000;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'(1));
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        req_valid = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_hold");
        rst     = 1'b0;
        rr_m    = 0;
        rdata_m = '0;
        run_txn(3'b011, 3'b000, 2, 16'hC0DE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(3'b010, 3'b000, 4, 16'hCAFE, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                @(negedge clk);
                check("gap_idle", 64'({grant, busy}), 64'(0));
            end
            randomize_fields();
            run_txn(N'($urandom_range(1, (1 << N) - 1)), N'($urandom),
                    int'($urandom_range(1, T + 1)), 16'($urandom),
                    1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
